ram_arbiter: RTL and testbench

//  Two-requester arbiter sharing the single rambus port between instruction

---
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one rambus port between instruction fetch (I, read-only)
// and load/store (D, read/write).
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_req/i_addr        fetch request; i_gnt accepts it in the same cycle
//   i_rvalid/i_rdata/i_err  registered fetch response, one cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata/d_wstrb  load/store request; d_gnt accepts it
//   d_rvalid/d_rdata/d_err  registered load/store response, one cycle after d_gnt
//   ram_addr/ram_wdata/ram_re/ram_we/ram_wstrb  rambus request, driven in grant cycle
//   ram_rdata           rambus read data (combinational read of ram_addr)
//
// Accesses outside [BASE_ADDR, END_ADDR) are granted but never reach the
// rambus; they complete with err=1 and rdata=0. Conflicts alternate between
// the two requesters. Address bits [1:0] are ignored by the word-wide rambus.

package typepkg;
    localparam logic [31:0] RAM_BASE_ADDR = 32'h0001_0000;
    localparam logic [31:0] RAM_END_ADDR  = 32'h0002_0000;
endpackage

module ram_arbiter #(
    parameter logic [31:0] BASE_ADDR = typepkg::RAM_BASE_ADDR,
    parameter logic [31:0] END_ADDR  = typepkg::RAM_END_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_re,
    output logic        ram_we,
    output logic [3:0]  ram_wstrb,
    input  logic [31:0] ram_rdata
);

    // Side that won the most recent grant; the other side wins a conflict.
    typedef enum logic {
        LAST_D = 1'b0,
        LAST_I = 1'b1
    } rr_e;

    rr_e         rr_q, rr_d;

    logic        i_rvalid_q, i_rvalid_d;
    logic [31:0] i_rdata_q,  i_rdata_d;
    logic        i_err_q,    i_err_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] d_rdata_q,  d_rdata_d;
    logic        d_err_q,    d_err_d;

    logic        sel_d;
    logic        gnt_any;
    logic        acc_we;
    logic        in_win;
    logic [31:0] acc_addr;
    logic [31:0] resp_rdata;

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        // Grant: D wins when alone, or in a conflict if I went last.
        sel_d    = d_req && (!i_req || (rr_q == LAST_I));
        d_gnt    = sel_d;
        i_gnt    = i_req && !sel_d;
        gnt_any  = i_req || d_req;

        acc_addr = sel_d ? d_addr : i_addr;
        acc_we   = sel_d && d_we;
        in_win   = (acc_addr >= BASE_ADDR) && (acc_addr < END_ADDR);

        ram_addr  = acc_addr;
        ram_wdata = d_wdata;
        ram_re    = gnt_any && in_win && !acc_we;
        ram_we    = gnt_any && in_win && acc_we;
        ram_wstrb = ram_we ? d_wstrb : 4'b0000;

        rr_d = rr_q;
        if (sel_d) begin
            rr_d = LAST_D;
        end else if (i_req) begin
            rr_d = LAST_I;
        end

        // Writes and out-of-window accesses return zero data.
        resp_rdata = (in_win && !acc_we) ? ram_rdata : 32'h0;

        // Response fields only change on a grant so they hold between pulses.
        i_rvalid_d = i_gnt;
        i_rdata_d  = i_gnt ? resp_rdata : i_rdata_q;
        i_err_d    = i_gnt ? !in_win    : i_err_q;
        d_rvalid_d = d_gnt;
        d_rdata_d  = d_gnt ? resp_rdata : d_rdata_q;
        d_err_d    = d_gnt ? !in_win    : d_err_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= LAST_I;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'h0;
            i_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_err_q    <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_err_q    <= i_err_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign i_err    = i_err_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by
// randomized requests, all checked against a word-array reference model.
module tb_ram_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] END_A = 32'h0000_1100;
    localparam int          WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_re, ram_we;
    logic [3:0]  ram_wstrb;

    ram_arbiter #(.BASE_ADDR(BASE), .END_ADDR(END_A)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re),
        .ram_we(ram_we), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Rambus memory seen by the DUT: combinational read, byte-strobed write.
    logic [31:0] bus_mem [WORDS];
    assign ram_rdata = bus_mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wstrb[b]) bus_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state.
    logic [31:0] model_mem [WORDS];
    bit          i_won_last;
    bit          exp_i_rvalid, exp_i_err, exp_d_rvalid, exp_d_err;
    logic [31:0] exp_i_rdata, exp_d_rdata;
    bit          last_gi, last_gd;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return END_A;
            1:       return END_A - 32'd4 + 32'($urandom_range(0, 3));
            2:       return BASE - 32'd4;
            3:       return $urandom;
            default: return BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(0, 3));
        endcase
    endfunction

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge after the model has absorbed this cycle.
    task automatic step();
        bit          gi, gd, win, we;
        logic [31:0] a, off;
        #1;
        check("i_rvalid", 32'(i_rvalid), 32'(exp_i_rvalid));
        check("i_rdata",  i_rdata,       exp_i_rdata);
        check("i_err",    32'(i_err),    32'(exp_i_err));
        check("d_rvalid", 32'(d_rvalid), 32'(exp_d_rvalid));
        check("d_rdata",  d_rdata,       exp_d_rdata);
        check("d_err",    32'(d_err),    32'(exp_d_err));

        gd = d_req && (!i_req || i_won_last);
        gi = i_req && !gd;
        check("i_gnt", 32'(i_gnt), 32'(gi));
        check("d_gnt", 32'(d_gnt), 32'(gd));

        a   = gd ? d_addr : i_addr;
        we  = gd && d_we;
        win = (a >= BASE) && (a < END_A);
        off = a - BASE;
        if (gi || gd) begin
            check("ram_addr",  ram_addr,        a);
            check("ram_re",    32'(ram_re),     32'(win && !we));
            check("ram_we",    32'(ram_we),     32'(win && we));
            check("ram_wstrb", 32'(ram_wstrb),  (win && we) ? 32'(d_wstrb) : 32'h0);
            if (win && we) check("ram_wdata", ram_wdata, d_wdata);
        end else begin
            check("idle_re",    32'(ram_re),    32'h0);
            check("idle_we",    32'(ram_we),    32'h0);
            check("idle_wstrb", 32'(ram_wstrb), 32'h0);
        end

        exp_i_rvalid = gi;
        exp_d_rvalid = gd;
        if (gi) begin
            exp_i_err   = !win;
            exp_i_rdata = win ? model_mem[off[7:2]] : 32'h0;
            i_won_last  = 1'b1;
        end
        if (gd) begin
            exp_d_err = !win;
            if (win && we) begin
                model_mem[off[7:2]] = merge(model_mem[off[7:2]], d_wdata, d_wstrb);
                exp_d_rdata = 32'h0;
            end else begin
                exp_d_rdata = win ? model_mem[off[7:2]] : 32'h0;
            end
            i_won_last = 1'b0;
        end
        last_gi = gi;
        last_gd = gd;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset at the current time, checks the response stage clears at
    // once and stays clear across a clock edge, then releases at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        check("rst_i_rdata",  i_rdata,       32'h0);
        check("rst_i_err",    32'(i_err),    32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("rst_d_rdata",  d_rdata,       32'h0);
        check("rst_d_err",    32'(d_err),    32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_i_rvalid", 32'(i_rvalid), 32'h0);
        @(negedge clk);
        rst_n        = 1'b1;
        i_won_last   = 1'b1;
        exp_i_rvalid = 1'b0; exp_i_err = 1'b0; exp_i_rdata = 32'h0;
        exp_d_rvalid = 1'b0; exp_d_err = 1'b0; exp_d_rdata = 32'h0;
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++) begin
            bus_mem[w]   = $urandom;
            model_mem[w] = bus_mem[w];
        end
        bus_mem[4]   = 32'hDEAD_BEEF;
        model_mem[4] = 32'hDEAD_BEEF;
        bus_mem[8]   = 32'h1122_3344;
        model_mem[8] = 32'h1122_3344;

        @(negedge clk);
        do_reset();

        // Single fetch with one-cycle latency.
        i_req = 1'b1; i_addr = BASE + 32'h10;
        step();
        i_req = 1'b0;
        check("t1_rvalid", 32'(i_rvalid), 32'h1);
        check("t1_rdata",  i_rdata,       32'hDEAD_BEEF);
        step();

        // Conflict after reset: D, I, D.
        do_reset();
        i_req = 1'b1; i_addr = BASE + 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = BASE + 32'h8;
        for (int k = 0; k < 3; k++) step();
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Partial write followed by a read of the same word.
        d_req = 1'b1; d_we = 1'b1; d_addr = BASE + 32'h20;
        d_wdata = 32'hAABB_CCDD; d_wstrb = 4'b0011;
        step();
        d_req = 1'b0; i_req = 1'b1; i_addr = BASE + 32'h20;
        step();
        i_req = 1'b0;
        step();
        check("t3_merge", i_rdata, 32'h1122_CCDD);

        // Read exactly at the window end.
        d_req = 1'b1; d_we = 1'b0; d_addr = END_A;
        step();
        d_req = 1'b0;
        check("t4_err",   32'(d_err), 32'h1);
        check("t4_rdata", d_rdata,    32'h0);
        step();

        // Fetch stream, one access per cycle.
        for (int k = 0; k < 4; k++) begin
            i_req = 1'b1; i_addr = BASE + 32'(k * 4);
            step();
        end
        i_req = 1'b0;
        step();

        // Reset while a grant is in flight, then the first conflict goes to D.
        i_req = 1'b1; i_addr = BASE + 32'h10;
        #1;
        check("t5_i_gnt", 32'(i_gnt), 32'h1);
        #1;
        do_reset();
        i_req = 1'b1; i_addr = BASE + 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = BASE + 32'h34;
        step();
        check("t5_d_first", 32'(last_gd), 32'h1);
        step();
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Randomized traffic; each requester holds its fields until granted.
        for (int n = 0; n < 600; n++) begin
            if (!i_req && $urandom_range(0, 2) != 0) begin
                i_req = 1'b1; i_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
                d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
            end
            step();
            if (last_gi) i_req = 1'b0;
            if (last_gd) d_req = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
